// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared FSM encoding, default parameters and WB bit positions for the MEM stage
package mem_stage_pkg;
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
   localparam int LATENCY_DEF    = 2;
   localparam int DEPTH_LOG2_DEF = 5;
   localparam int REGWRITE       = 0;
   localparam int MEMTOREG       = 1;
endpackage

// File: rtl/mem_stage_data_memory.sv
// data_memory: 2^DEPTH_LOG2 x 32 word store, synchronous write, combinational read
// ports: clk clock | we write enable | addr word index | wdata store data | rdata read data
module data_memory #(
   parameter int DEPTH_LOG2 = 5
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);
   logic [31:0] mem [2**DEPTH_LOG2];
   always_ff @(posedge clk)
      if (we) mem[addr] <= wdata;
   assign rdata = mem[addr];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: multi-cycle pipeline MEM stage with stall FSM, data memory and MEM/WB register
// ports: clk_i clock | rst_i async active-low reset | WB_i/MemRead_i/MemWrite_i controls from EX/MEM
//        RegData_i ALU result / byte address | MemData_i store data | RegAddr_i destination register
//        stall_o upstream freeze | WB_o, RegData_o, MemData_o (load data), RegAddr_o MEM/WB register
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int LATENCY    = LATENCY_DEF,
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [1:0]  WB_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [31:0] RegData_i,
   input  logic [31:0] MemData_i,
   input  logic [4:0]  RegAddr_i,
   output logic        stall_o,
   output logic [1:0]  WB_o,
   output logic [31:0] RegData_o,
   output logic [31:0] MemData_o,
   output logic [4:0]  RegAddr_o
);
   state_t                state;
   logic [3:0]            cnt;
   logic                  req;
   logic                  done;
   logic [DEPTH_LOG2-1:0] idx;
   logic [31:0]           rdata;
   logic                  unused_addr;

   assign req     = MemRead_i | MemWrite_i;
   assign done    = (state == BUSY) && (cnt == 4'd0);
   // an idle request stalls immediately; a busy access releases the stall on its completion cycle
   assign stall_o = (state == IDLE) ? req : !done;
   // byte address to word index; upper bits drop out so addresses wrap
   assign idx         = RegData_i[DEPTH_LOG2+1:2];
   assign unused_addr = ^{RegData_i[31:DEPTH_LOG2+2], RegData_i[1:0]};

   // the write fires only on the completion edge, so a reset mid-access (state forced IDLE) never writes
   data_memory #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
      .clk   (clk_i),
      .we    (done && MemWrite_i),
      .addr  (idx),
      .wdata (MemData_i),
      .rdata (rdata)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         WB_o      <= 2'b00;
         RegData_o <= '0;
         MemData_o <= '0;
         RegAddr_o <= '0;
      end else if (stall_o) begin
         WB_o <= 2'b00;
         if (state == IDLE) begin
            state <= BUSY;
            cnt   <= 4'(LATENCY - 1);
         end else begin
            cnt <= cnt - 4'd1;
         end
      end else begin
         state     <= IDLE;
         WB_o      <= WB_i;
         RegData_o <= RegData_i;
         RegAddr_o <= RegAddr_i;
         // a write wins over a simultaneous read, so load data only for pure reads
         MemData_o <= (done && MemRead_i && !MemWrite_i) ? rdata : '0;
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage against an array-based reference model
module tb_mem_stage;
   localparam int LAT   = 2;
   localparam int DL    = 5;
   localparam int WORDS = 1 << DL;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [1:0]  WB_i = 2'b00;
   logic        MemRead_i = 1'b0;
   logic        MemWrite_i = 1'b0;
   logic [31:0] RegData_i = '0;
   logic [31:0] MemData_i = '0;
   logic [4:0]  RegAddr_i = '0;
   logic        stall_o;
   logic [1:0]  WB_o;
   logic [31:0] RegData_o;
   logic [31:0] MemData_o;
   logic [4:0]  RegAddr_o;

   int vectors = 0;
   int errors  = 0;
   logic [31:0] model [WORDS];

   mem_stage #(.LATENCY(LAT), .DEPTH_LOG2(DL)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .WB_i       (WB_i),
      .MemRead_i  (MemRead_i),
      .MemWrite_i (MemWrite_i),
      .RegData_i  (RegData_i),
      .MemData_i  (MemData_i),
      .RegAddr_i  (RegAddr_i),
      .stall_o    (stall_o),
      .WB_o       (WB_o),
      .RegData_o  (RegData_o),
      .MemData_o  (MemData_o),
      .RegAddr_o  (RegAddr_o)
   );

   always #5 clk_i = ~clk_i;

   // reference: memory as a plain array indexed by (byte address / 4) mod size
   function automatic logic [31:0] ref_op(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
      int i;
      i = int'((addr / 4) % WORDS);
      if (wr) begin
         model[i] = data;
         return 32'h0;
      end
      return rd ? model[i] : 32'h0;
   endfunction

   // drives one instruction just after a rising edge, observes it until it leaves the stage
   task automatic run_op(input logic [1:0] wb, input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] ra,
                         output int stalls, output bit bubble_ok,
                         output logic [1:0] wb_o, output logic [31:0] rd_o, output logic [31:0] md_o, output logic [4:0] ra_o);
      logic [31:0] p_rd, p_md;
      logic [4:0]  p_ra;
      p_rd = RegData_o; p_md = MemData_o; p_ra = RegAddr_o;
      WB_i = wb; MemRead_i = rd; MemWrite_i = wr; RegData_i = addr; MemData_i = data; RegAddr_i = ra;
      stalls = 0;
      bubble_ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         if (!stall_o) break;
         stalls++;
         @(posedge clk_i);
         #1;
         if (WB_o !== 2'b00 || RegData_o !== p_rd || MemData_o !== p_md || RegAddr_o !== p_ra) bubble_ok = 1'b0;
      end
      @(posedge clk_i);
      #1;
      wb_o = WB_o; rd_o = RegData_o; md_o = MemData_o; ra_o = RegAddr_o;
      MemRead_i = 1'b0; MemWrite_i = 1'b0; WB_i = 2'b00;
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      #3;
      vectors++;
      if ({stall_o, WB_o, RegData_o, MemData_o, RegAddr_o} !== '0) begin
         errors++;
         $display("FAIL reset: stall=%b wb=%b rd=%h md=%h ra=%0d, want all 0", stall_o, WB_o, RegData_o, MemData_o, RegAddr_o);
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      vectors++;
      if ({stall_o, WB_o, RegData_o, MemData_o, RegAddr_o} !== '0) begin
         errors++;
         $display("FAIL reset_release: stall=%b wb=%b rd=%h md=%h ra=%0d, want all 0", stall_o, WB_o, RegData_o, MemData_o, RegAddr_o);
      end
   endtask

   task automatic test_fill();
      int st; bit ok; logic [1:0] w; logic [31:0] r, m, a, d; logic [4:0] g;
      for (int i = 0; i < WORDS; i++) begin
         a = ($urandom() & ~32'h7C) | (32'(i) << 2);
         d = $urandom();
         run_op(2'b00, 1'b0, 1'b1, a, d, 5'(i), st, ok, w, r, m, g);
         void'(ref_op(1'b0, 1'b1, a, d));
         vectors++;
         if (st != LAT || !ok || {w, r, m, g} !== {2'b00, a, 32'h0, 5'(i)}) begin
            errors++;
            $display("FAIL fill[%0d]: stalls=%0d bubble=%b wb=%b rd=%h md=%h ra=%0d, want stalls=%0d rd=%h md=0", i, st, ok, w, r, m, g, LAT, a);
         end
      end
   endtask

   task automatic test_alu();
      int st; bit ok; logic [1:0] w; logic [31:0] r, m; logic [4:0] g;
      run_op(2'b01, 1'b0, 1'b0, 32'h1234, 32'hFFFF_FFFF, 5'd5, st, ok, w, r, m, g);
      vectors++;
      if (st != 0 || {w, r, m, g} !== {2'b01, 32'h1234, 32'h0, 5'd5}) begin
         errors++;
         $display("FAIL alu: stalls=%0d wb=%b rd=%h md=%h ra=%0d, want 0/01/1234/0/5", st, w, r, m, g);
      end
   endtask

   task automatic test_store_load();
      int st; bit ok; logic [1:0] w; logic [31:0] r, m; logic [4:0] g;
      run_op(2'b00, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0, st, ok, w, r, m, g);
      void'(ref_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF));
      vectors++;
      if (st != LAT || !ok || {w, m} !== {2'b00, 32'h0}) begin
         errors++;
         $display("FAIL store: stalls=%0d bubble=%b wb=%b md=%h, want %0d/1/00/0", st, ok, w, m, LAT);
      end
      run_op(2'b11, 1'b1, 1'b0, 32'h10, 32'h0, 5'd7, st, ok, w, r, m, g);
      vectors++;
      if (st != LAT || !ok || {w, r, m, g} !== {2'b11, 32'h10, 32'hDEADBEEF, 5'd7}) begin
         errors++;
         $display("FAIL load: stalls=%0d bubble=%b wb=%b rd=%h md=%h ra=%0d, want %0d/1/11/10/deadbeef/7", st, ok, w, r, m, g, LAT);
      end
      run_op(2'b11, 1'b1, 1'b0, 32'h93, 32'h0, 5'd8, st, ok, w, r, m, g);
      vectors++;
      if (st != LAT || m !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL wrap_load: stalls=%0d md=%h, want %0d/deadbeef", st, m, LAT);
      end
   endtask

   task automatic test_reset_busy();
      int st; bit ok; logic [1:0] w; logic [31:0] r, m; logic [4:0] g;
      WB_i = 2'b01; MemWrite_i = 1'b1; RegData_i = 32'h10; MemData_i = 32'h0; RegAddr_i = 5'd3;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      MemWrite_i = 1'b0;
      #1;
      vectors++;
      if ({stall_o, WB_o, RegData_o, MemData_o, RegAddr_o} !== '0) begin
         errors++;
         $display("FAIL reset_busy: stall=%b wb=%b rd=%h md=%h ra=%0d, want all 0", stall_o, WB_o, RegData_o, MemData_o, RegAddr_o);
      end
      MemWrite_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      MemWrite_i = 1'b0;
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      run_op(2'b11, 1'b1, 1'b0, 32'h10, 32'h0, 5'd1, st, ok, w, r, m, g);
      vectors++;
      if (st != LAT || m !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL reset_busy_mem: stalls=%0d md=%h, want %0d/deadbeef", st, m, LAT);
      end
   endtask

   task automatic test_both();
      int st; bit ok; logic [1:0] w; logic [31:0] r, m; logic [4:0] g;
      run_op(2'b01, 1'b1, 1'b1, 32'h0, 32'h55, 5'd9, st, ok, w, r, m, g);
      void'(ref_op(1'b1, 1'b1, 32'h0, 32'h55));
      vectors++;
      if (st != LAT || m !== 32'h0) begin
         errors++;
         $display("FAIL rw_both: stalls=%0d md=%h, want %0d/0", st, m, LAT);
      end
      run_op(2'b10, 1'b1, 1'b0, 32'h0, 32'h0, 5'd9, st, ok, w, r, m, g);
      vectors++;
      if (m !== 32'h55) begin
         errors++;
         $display("FAIL rw_both_read: md=%h, want 55", m);
      end
   endtask

   task automatic test_back_to_back();
      int st; bit ok; logic [1:0] w, wb; logic [31:0] r, m, a, d, e; logic [4:0] g, ra; logic rd, wr;
      for (int n = 0; n < 80; n++) begin
         wb = 2'($urandom_range(0, 3));
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 2) == 0);
         a  = $urandom();
         d  = $urandom();
         ra = 5'($urandom_range(0, 31));
         run_op(wb, rd, wr, a, d, ra, st, ok, w, r, m, g);
         e = ref_op(rd, wr, a, d);
         vectors++;
         if (st != ((rd || wr) ? LAT : 0) || !ok || {w, r, m, g} !== {wb, a, e, ra}) begin
            errors++;
            $display("FAIL b2b[%0d] rd=%b wr=%b: stalls=%0d bubble=%b wb=%b rd=%h md=%h ra=%0d, want wb=%b rd=%h md=%h ra=%0d",
                     n, rd, wr, st, ok, w, r, m, g, wb, a, e, ra);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_alu();
      test_store_load();
      test_reset_busy();
      test_both();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning wait cycles per memory access; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_LOG2, default 5, meaning data memory depth of 2^DEPTH_LOG2 words of 32 bits.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port WB_i, input, 2 bits: writeback controls from EX/MEM; bit0 is RegWrite, bit1 is MemtoReg.
REQ-006 SHALL have ports MemRead_i and MemWrite_i, input, 1 bit each: memory controls from EX/MEM.
REQ-007 SHALL have port RegData_i, input, 32 bits: ALU result, used as byte address.
REQ-008 SHALL have port MemData_i, input, 32 bits: store data.
REQ-009 SHALL have port RegAddr_i, input, 5 bits: destination register number.
REQ-010 SHALL have port stall_o, output, 1 bit: freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-011 SHALL have ports WB_o (2 bits), RegData_o (32 bits), MemData_o (32 bits, load data) and RegAddr_o (5 bits), all outputs: the registered MEM/WB stage.

Function
REQ-012 SHALL define request as MemRead_i OR MemWrite_i.
REQ-013 SHALL implement FSM states IDLE and BUSY, plus a 4-bit wait counter cnt.
REQ-014 IDLE with request SHALL drive stall_o=1 combinationally, go to BUSY and load cnt=LATENCY-1.
REQ-015 IDLE with no request SHALL keep stall_o=0 and capture WB_i, RegData_i and RegAddr_i into the MEM/WB outputs, with MemData_o=0.
REQ-016 BUSY with cnt!=0 SHALL drive stall_o=1 and decrement cnt.
REQ-017 BUSY with cnt==0 SHALL drive stall_o=0, complete the access at that edge, capture the MEM/WB outputs and return to IDLE.
REQ-018 Every memory instruction SHALL therefore occupy the stage for exactly LATENCY+1 cycles; a non-memory instruction occupies it for 1 cycle.
REQ-019 While stall_o=1, WB_o SHALL be registered as 2'b00 (bubble); RegData_o, MemData_o and RegAddr_o SHALL hold.
REQ-020 Upstream SHALL hold all inputs stable while stall_o=1; the block samples address and data only at completion.
REQ-021 SHALL form the word index as RegData_i[DEPTH_LOG2+1:2]; bits [1:0] are ignored, and upper bits are ignored so addresses wrap modulo the memory size.
REQ-022 A write SHALL store MemData_i at the completion edge; MemData_o for a write SHALL be 0.
REQ-023 A read SHALL register the memory word into MemData_o at the completion edge.
REQ-024 When MemRead_i and MemWrite_i are both 1, the write SHALL take effect and MemData_o SHALL be 0.
REQ-025 Back-to-back memory instructions SHALL each incur the full LATENCY+1 cycles, with no overlap.
REQ-026 A read at the completion edge SHALL return the value stored by any earlier completed write to the same index.

Reset
REQ-027 rst_i low SHALL immediately force state=IDLE, cnt=0, WB_o=0, RegData_o=0, MemData_o=0 and RegAddr_o=0, which makes stall_o=0 unless a request is present.
REQ-028 Reset during BUSY SHALL abort the access with no memory write.
REQ-029 Memory contents SHALL NOT be reset.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, default LATENCY, DEPTH_LOG2 and the WB bit indices (REGWRITE=0, MEMTOREG=1).
REQ-031 The storage SHALL be a sub-module data_memory: synchronous write, combinational read, parameter DEPTH_LOG2.
REQ-032 The FSM, counter and MEM/WB register SHALL reside in mem_stage.

Verification
REQ-033 Scenario: ALU op with WB_i=01, RegData_i=0x1234, RegAddr_i=5 and no request -> next edge WB_o=01, RegData_o=0x1234, RegAddr_o=5, stall_o=0 throughout.
REQ-034 Scenario: with LATENCY=2, store MemData_i=0xDEADBEEF to address 0x10 -> stall_o high 2 cycles, WB_o=00 during stall, word 4 written on the 3rd edge.
REQ-035 Scenario: load from address 0x10 after REQ-034 -> stall_o high 2 cycles, then MemData_o=0xDEADBEEF with WB_i=11 propagated.
REQ-036 Scenario: load from address 0x90 with DEPTH_LOG2=5 -> returns word 4 (wrap), value 0xDEADBEEF.
REQ-037 Scenario: rst_i low mid-BUSY during a store of 0x0 to 0x10 -> outputs 0, stall_o=0, word 4 still 0xDEADBEEF.
REQ-038 Scenario: MemRead_i=MemWrite_i=1 with store data 0x55 to address 0x0 -> word 0 becomes 0x55 and MemData_o=0.
